// File: rtl/neuron_mac_stream_if.sv
// neuron_mac_stream_if -- handshake bundle for one neuron compute block.
//   start/bias          : result request (bias latched with the accepted start)
//   in_valid/in_ready   : din/w beat stream
//   out_valid/out_ready : result stream, out_data plus out_sat/acc_ovf flags
//   busy                : block is mid-result
// master = producer/consumer side, slave = the neuron block.
interface neuron_mac_stream_if #(
  parameter int DATA_W = 8,
  parameter int W_W    = 8,
  parameter int BIAS_W = 8,
  parameter int OUT_W  = 8
);
  logic                     start;
  logic signed [BIAS_W-1:0] bias;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] din;
  logic signed [W_W-1:0]    w;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_sat;
  logic                     acc_ovf;
  logic                     busy;

  modport master (
    output start, bias, in_valid, din, w, out_ready,
    input  in_ready, out_valid, out_data, out_sat, acc_ovf, busy
  );

  modport slave (
    input  start, bias, in_valid, din, w, out_ready,
    output in_ready, out_valid, out_data, out_sat, acc_ovf, busy
  );
endinterface

// File: rtl/neuron_mac_stream.sv
// neuron_mac_stream -- single-neuron MAC: sums N_INPUTS signed din*w products
// into a saturating accumulator, adds bias, shifts right by FRAC_SHIFT and
// applies ReLU (ACT_MODE=0) or linear (ACT_MODE=1) clamping to OUT_W bits.
//   clk, rst : clock, synchronous active-high reset (aborts any run)
//   io       : neuron_mac_stream_if.slave (start/bias, beat stream, result)
module neuron_mac_stream #(
  parameter int N_INPUTS   = 256,
  parameter int DATA_W     = 8,
  parameter int W_W        = 8,
  parameter int BIAS_W     = 8,
  parameter int ACC_W      = 24,
  parameter int OUT_W      = 8,
  parameter int FRAC_SHIFT = 0,
  parameter int ACT_MODE   = 0
) (
  input logic clk,
  input logic rst,
  neuron_mac_stream_if.slave io
);
  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam int P_W   = DATA_W + W_W;
  localparam int AW1   = ACC_W + 1;
  // Clamp compare width: wide enough for both the accumulator and OUT_W bounds.
  localparam int SW    = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [SW-1:0]    OMAX    = SW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  // ReLU floor is 0; linear floor is -2^(OUT_W-1) == ~OMAX.
  localparam logic signed [SW-1:0]    OMIN    = (ACT_MODE == 0) ? '0 : ~OMAX;

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DRAIN, S_BIAS, S_ACT, S_OUT} state_t;
  state_t state, state_n;

  logic [CNT_W-1:0]         cnt;
  logic signed [BIAS_W-1:0] bias_q;
  logic signed [P_W-1:0]    mult;
  logic                     mult_vld;
  logic signed [ACC_W-1:0]  acc;
  logic                     out_valid_q, out_sat_q, acc_ovf_q;
  logic signed [OUT_W-1:0]  out_data_q;

  logic in_ready, beat, last_beat;
  assign in_ready  = (state == S_ACCUM);
  assign beat      = io.in_valid & in_ready;
  assign last_beat = beat && (cnt == CNT_W'(N_INPUTS - 1));

  // FSM
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (io.start) state_n = S_ACCUM;
      S_ACCUM: if (last_beat) state_n = S_DRAIN;
      S_DRAIN: state_n = S_BIAS;
      S_BIAS:  state_n = S_ACT;
      S_ACT:   state_n = S_OUT;
      S_OUT:   if (io.out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Saturating accumulate: one guard bit catches overflow of either sign.
  // Products and bias never collide: mult_vld is already clear in BIAS.
  logic                    add_en, sum_ovf;
  logic signed [AW1-1:0]   addend, sum;
  logic signed [ACC_W-1:0] acc_sat;

  always_comb begin
    add_en  = mult_vld | (state == S_BIAS);
    addend  = (state == S_BIAS) ? AW1'(bias_q) : AW1'(mult);
    sum     = {acc[ACC_W-1], acc} + addend;
    sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
    acc_sat = sum_ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
  end

  // Activation clamp; ReLU zeroing of negatives is not flagged as saturation.
  logic signed [ACC_W-1:0] shifted;
  logic signed [SW-1:0]    s_w, act_val;
  logic                    act_sat;

  always_comb begin
    shifted = acc >>> FRAC_SHIFT;
    s_w     = SW'(shifted);
    act_val = s_w;
    act_sat = 1'b0;
    if (s_w > OMAX) begin
      act_val = OMAX;
      act_sat = 1'b1;
    end else if (s_w < OMIN) begin
      act_val = OMIN;
      act_sat = (ACT_MODE != 0);
    end
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      bias_q      <= '0;
      mult        <= '0;
      mult_vld    <= 1'b0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      acc_ovf_q   <= 1'b0;
    end else begin
      mult_vld <= beat;
      if (beat) begin
        mult <= P_W'(io.din) * P_W'(io.w);
        cnt  <= cnt + CNT_W'(1);
      end
      if (add_en) begin
        acc <= acc_sat;
        if (sum_ovf) acc_ovf_q <= 1'b1;
      end
      case (state)
        S_IDLE: if (io.start) begin
          bias_q    <= io.bias;
          acc       <= '0;
          acc_ovf_q <= 1'b0;
          cnt       <= '0;
        end
        S_ACT: begin
          out_data_q  <= OUT_W'(act_val);
          out_sat_q   <= act_sat;
          out_valid_q <= 1'b1;
        end
        S_OUT: if (io.out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign io.in_ready  = in_ready;
  assign io.busy      = (state != S_IDLE);
  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;
  assign io.out_sat   = out_sat_q;
  assign io.acc_ovf   = acc_ovf_q;
endmodule

// File: tb/tb_neuron_mac_stream.sv
// Five neuron instances (N_INPUTS=4) share one stimulus stream:
//   u0 ReLU; u1 linear; u2 linear FRAC_SHIFT=10; u3 linear FRAC_SHIFT=8;
//   u4 linear ACC_W=17.
module tb_neuron_mac_stream;
  localparam int ND = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              start, in_valid, out_ready;
  logic signed [7:0] bias, din, w;

  logic [ND-1:0]     ov, ir, osat, ovf, bsy;
  logic signed [7:0] od [ND];

  for (genvar g = 0; g < ND; g++) begin : gd
    neuron_mac_stream_if ifc ();
    assign ifc.start     = start;
    assign ifc.bias      = bias;
    assign ifc.in_valid  = in_valid;
    assign ifc.din       = din;
    assign ifc.w         = w;
    assign ifc.out_ready = out_ready;
    assign ov[g]   = ifc.out_valid;
    assign ir[g]   = ifc.in_ready;
    assign osat[g] = ifc.out_sat;
    assign ovf[g]  = ifc.acc_ovf;
    assign bsy[g]  = ifc.busy;
    assign od[g]   = ifc.out_data;

    neuron_mac_stream #(
      .N_INPUTS  (4),
      .ACC_W     ((g == 4) ? 17 : 24),
      .FRAC_SHIFT((g == 2) ? 10 : (g == 3) ? 8 : 0),
      .ACT_MODE  ((g == 0) ? 0 : 1)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .io (ifc)
    );
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int t0, lat;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int b);
    start = 1'b1;
    bias  = 8'(b);
    step();
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic feed(input int d0, input int d1, input int d2, input int d3,
                      input int wv, input bit tog, input int nb);
    int d[4];
    int k = 0;
    int g = 0;
    bit p = 1'b1;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    w = 8'(wv);
    while (k < nb && g < 64) begin
      in_valid = tog ? p : 1'b1;
      p   = ~p;
      din = 8'(d[k]);
      @(posedge clk);
      if (in_valid) k++;
      #1;
      g++;
    end
    in_valid = 1'b0;
    din      = '0;
  endtask

  task automatic wait_out();
    int g = 0;
    while (!ov[0] && g < 40) begin
      step();
      g++;
    end
    if (!ov[0]) chk("out_valid_timeout", 0, 1);
    lat = cyc - t0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    bias = '0; din = '0; w = '0;
    repeat (3) step();
    chk("rst_out_valid", ov[0], 0);
    chk("rst_out_data", od[0], 0);
    chk("rst_out_sat", osat[0], 0);
    chk("rst_acc_ovf", ovf[0], 0);
    chk("rst_busy", bsy[0], 0);
    chk("rst_in_ready", ir[0], 0);
    rst = 1'b0;
    step();

    // 1: 1+2+3+4-3 = 7, out_valid 7 edges after start
    start_run(-3);
    chk("c1_busy", bsy[0], 1);
    chk("c1_in_ready", ir[0], 1);
    feed(1, 2, 3, 4, 1, 1'b0, 4);
    chk("c1_in_ready_after_last", ir[0], 0);
    wait_out();
    chk("c1_latency", lat, 7);
    chk("c1_data_relu", od[0], 7);
    chk("c1_sat", osat[0], 0);
    chk("c1_ovf", ovf[0], 0);
    chk("c1_data_lin", od[1], 7);
    step();
    chk("c1_valid_drop", ov[0], 0);
    chk("c1_idle", bsy[0], 0);

    // 2: 4 * -50 = -200
    start_run(0);
    feed(-10, -10, -10, -10, 5, 1'b0, 4);
    wait_out();
    chk("c2_relu_data", od[0], 0);
    chk("c2_relu_sat", osat[0], 0);
    chk("c2_lin_data", od[1], -128);
    chk("c2_lin_sat", osat[1], 1);
    step();

    // 3: 40000 >>> 10 = 39, 40000 >>> 8 = 156 -> 127
    start_run(0);
    feed(100, 100, 100, 100, 100, 1'b0, 4);
    wait_out();
    chk("c3_fs10_data", od[2], 39);
    chk("c3_fs10_sat", osat[2], 0);
    chk("c3_fs8_data", od[3], 127);
    chk("c3_fs8_sat", osat[3], 1);
    step();

    // 4: gapped beats, back-pressured result, stray start during OUT
    out_ready = 1'b0;
    start_run(-3);
    feed(1, 2, 3, 4, 1, 1'b1, 4);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      chk("c4_hold_valid", ov[0], 1);
      chk("c4_hold_data", od[0], 7);
      chk("c4_in_ready", ir[0], 0);
      chk("c4_busy", bsy[0], 1);
      start = (i == 2);
      step();
    end
    start = 1'b0;
    out_ready = 1'b1;
    step();
    chk("c4_valid_drop", ov[0], 0);
    chk("c4_idle", bsy[0], 0);
    step();
    chk("c4_start_ignored", bsy[0], 0);

    // 5: 4 * 16384 = 65536 clamps at 65535 in a 17-bit accumulator
    start_run(5);
    feed(-128, -128, -128, -128, -128, 1'b0, 4);
    wait_out();
    chk("c5_ovf17", ovf[4], 1);
    chk("c5_data17", od[4], 127);
    chk("c5_sat17", osat[4], 1);
    chk("c5_ovf24", ovf[1], 0);
    chk("c5_data24", od[1], 127);
    step();
    chk("c5_ovf_sticky", ovf[4], 1);

    // 6: abort after 2 beats, then a clean run
    start_run(-3);
    chk("c6_start_clears_ovf", ovf[4], 0);
    feed(1, 2, 3, 4, 1, 1'b0, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("c6_rst_valid", ov[0], 0);
    chk("c6_rst_data", od[4], 0);
    chk("c6_rst_sat", osat[4], 0);
    chk("c6_rst_ovf", ovf[4], 0);
    chk("c6_rst_busy", bsy[0], 0);
    chk("c6_rst_in_ready", ir[0], 0);
    start_run(-3);
    feed(1, 2, 3, 4, 1, 1'b0, 4);
    wait_out();
    chk("c6_data", od[0], 7);
    chk("c6_data17", od[4], 7);
    chk("c6_ovf17", ovf[4], 0);
    chk("c6_latency", lat, 7);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
